// File: rtl/fp_mul_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_pkg
// Shared definitions for the single-precision multiplier dispatcher:
//   st_t            dispatcher FSM state encoding
//   QNAN            canonical quiet NaN returned when the watchdog fires
//   field constants sign / exponent / mantissa widths and bit offsets
// -----------------------------------------------------------------------------
package fp_mul_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDrain = 2'd3
   } st_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   localparam int unsigned SIGN_BIT = 31;
   localparam int unsigned EXP_W    = 8;
   localparam int unsigned EXP_LSB  = 23;
   localparam int unsigned MANT_W   = 23;
   localparam int unsigned MANT_LSB = 0;

endpackage

// File: rtl/fp_op_fifo.sv
// -----------------------------------------------------------------------------
// fp_op_fifo
// Synchronous operand FIFO (first-word fall-through read port).
// Ports:
//   clk_i    clock, all state on posedge
//   rst_ni   synchronous active-low reset (empties the FIFO)
//   push_i   write wdata_i (ignored when full)
//   pop_i    drop the head entry (ignored when empty)
//   wdata_i  entry to write
//   rdata_o  current head entry
//   count_o  occupancy 0..DEPTH
//   full_o   no free entry
//   empty_o  no valid entry
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fp_op_fifo
   import fp_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fp_mul_dispatcher.sv
// -----------------------------------------------------------------------------
// fp_mul_dispatcher
// Feeds a single-precision multiplier one operand pair at a time from a small
// FIFO and returns each product through a valid/ready output register, in order.
// Ports:
//   clk, rst               clock; synchronous active-low reset
//   a_in, b_in, in_valid   producer operand pair offer
//   in_ready               FIFO has room (low while in reset)
//   mul_op1, mul_op2       registered operands to the multiplier
//   mul_in_rdy             one-cycle start pulse to the multiplier
//   mul_res, mul_res_rdy   multiplier result and its one-cycle strobe
//   out_res, out_valid     captured product, held until out_ready
//   out_ready              consumer accept
//   busy                   FSM not idle or FIFO not empty
//   fifo_count             FIFO occupancy
//   timeout_err            sticky watchdog flag (FP_MUL_TIMEOUT_EN only)
// Build option: define FP_MUL_TIMEOUT_EN to add a WAIT-state watchdog that
// returns QNAN after TIMEOUT_CYCLES cycles without a result strobe.
// -----------------------------------------------------------------------------
module fp_mul_dispatcher
   import fp_mul_pkg::*;
#(
   parameter int unsigned SIZE           = 32,
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SIZE-1:0]        a_in,
   input  logic [SIZE-1:0]        b_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [SIZE-1:0]        mul_op1,
   output logic [SIZE-1:0]        mul_op2,
   output logic                   mul_in_rdy,
   input  logic [SIZE-1:0]        mul_res,
   input  logic                   mul_res_rdy,
   output logic [SIZE-1:0]        out_res,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
`ifdef FP_MUL_TIMEOUT_EN
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   timeout_err
`else
   output logic [$clog2(DEPTH):0] fifo_count
`endif
);

   st_t               state_q, state_d;
   logic [SIZE-1:0]   op1_q, op1_d;
   logic [SIZE-1:0]   op2_q, op2_d;
   logic              in_rdy_q, in_rdy_d;
   logic [SIZE-1:0]   res_q, res_d;
   logic              out_valid_q, out_valid_d;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [2*SIZE-1:0] fifo_head;

`ifdef FP_MUL_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLast = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          err_q, err_d;
`endif

   // Gate with rst so no push is advertised while the block is held in reset.
   assign in_ready  = !fifo_full && rst;
   assign fifo_push = in_valid && in_ready;

   fp_op_fifo #(
      .WIDTH (2 * SIZE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i ({a_in, b_in}),
      .rdata_o (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      fifo_pop    = 1'b0;
      res_d       = res_q;
      out_valid_d = out_valid_q;
`ifdef FP_MUL_TIMEOUT_EN
      tcnt_d      = tcnt_q;
      err_d       = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
`ifdef FP_MUL_TIMEOUT_EN
            tcnt_d  = '0;
`endif
         end
         StWait: begin
            if (mul_res_rdy) begin
               res_d       = mul_res;
               out_valid_d = 1'b1;
               state_d     = StDrain;
`ifdef FP_MUL_TIMEOUT_EN
            end else if (tcnt_q == TLast) begin
               res_d       = QNAN;
               out_valid_d = 1'b1;
               err_d       = 1'b1;
               state_d     = StDrain;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
`endif
            end
         end
         StDrain: begin
            // Leaving DRAIN only on a handshake keeps a gap of at least one cycle
            // between a result strobe and the next start pulse.
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_d  = StIssue;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      op1_d    = fifo_pop ? fifo_head[2*SIZE-1:SIZE] : op1_q;
      op2_d    = fifo_pop ? fifo_head[SIZE-1:0]      : op2_q;
      in_rdy_d = (state_d == StIssue);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         op1_q       <= '0;
         op2_q       <= '0;
         in_rdy_q    <= 1'b0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef FP_MUL_TIMEOUT_EN
         tcnt_q      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         in_rdy_q    <= in_rdy_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
`ifdef FP_MUL_TIMEOUT_EN
         tcnt_q      <= tcnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign mul_op1    = op1_q;
   assign mul_op2    = op2_q;
   assign mul_in_rdy = in_rdy_q;
   assign out_res    = res_q;
   assign out_valid  = out_valid_q;
   assign busy       = (state_q != StIdle) || !fifo_empty;
`ifdef FP_MUL_TIMEOUT_EN
   assign timeout_err = err_q;
`endif

endmodule

// File: tb/tb_fp_mul_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_dispatcher
// Bench for fp_mul_dispatcher with a behavioural multiplier stand-in that
// answers each start pulse after a random latency. Expected products are
// queued when a pair is accepted and compared when out_valid/out_ready fire.
// Define FP_MUL_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
// -----------------------------------------------------------------------------
module tb_fp_mul_dispatcher;

   localparam int unsigned SIZE   = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned TO_CYC = 8;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [SIZE-1:0]        a_in = '0, b_in = '0;
   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic [SIZE-1:0]        mul_op1, mul_op2;
   logic                   mul_in_rdy;
   logic [SIZE-1:0]        mul_res = '0;
   logic                   mul_res_rdy = 1'b0;
   logic [SIZE-1:0]        out_res;
   logic                   out_valid;
   logic                   out_ready = 1'b1;
   logic                   busy;
   logic [$clog2(DEPTH):0] fifo_count;
`ifdef FP_MUL_TIMEOUT_EN
   logic                   timeout_err;
`endif

   always #5 clk = ~clk;

   fp_mul_dispatcher #(
      .SIZE           (SIZE),
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .a_in        (a_in),
      .b_in        (b_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .mul_op1     (mul_op1),
      .mul_op2     (mul_op2),
      .mul_in_rdy  (mul_in_rdy),
      .mul_res     (mul_res),
      .mul_res_rdy (mul_res_rdy),
      .out_res     (out_res),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
`ifdef FP_MUL_TIMEOUT_EN
      .fifo_count  (fifo_count),
      .timeout_err (timeout_err)
`else
      .fifo_count  (fifo_count)
`endif
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   // Multiplier stand-in state.
   bit          hang        = 1'b0;  // never answer
   bit          glitch      = 1'b0;  // random stray strobes while nothing is in flight
   bit          pending     = 1'b0;
   bit          prev_in_rdy = 1'b0;
   bit          genuine     = 1'b0;
   logic [31:0] lat_op1, lat_op2;
   int          lat_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // IEEE products for the directed pairs; any other pair gets a scrambled
   // value so that swapped or stale operands are visible in the output.
   function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
         {32'h3FC0_0000, 32'h3FC0_0000}: return 32'h4010_0000;
         {32'h7F80_0000, 32'h0000_0000}: return 32'hFFC0_0000;
         default:                        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
      endcase
   endfunction

   // Everything sampled mid-cycle; stand-in outputs change here too.
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         pending     = 1'b0;
         genuine     = 1'b0;
         prev_in_rdy = 1'b0;
         mul_res_rdy = 1'b0;
      end else begin
         if (genuine) begin
            check("res_to_valid", 32'(out_valid), 32'd1);
            genuine = 1'b0;
         end
         mul_res_rdy = 1'b0;
         if (in_valid && in_ready) exp_q.push_back(mul_model(a_in, b_in));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check("sb_result", out_res, exp_q.pop_front());
         end
         if (mul_in_rdy) begin
            check("in_rdy_width", 32'(prev_in_rdy), 32'd0);
            check("issue_while_busy", 32'(pending), 32'd0);
            check("issue_with_out_valid", 32'(out_valid), 32'd0);
            pending = 1'b1;
            lat_op1 = mul_op1;
            lat_op2 = mul_op2;
            lat_cnt = int'($urandom_range(1, 5));
         end else if (pending) begin
            check("op1_stable", mul_op1, lat_op1);
            check("op2_stable", mul_op2, lat_op2);
            lat_cnt--;
            if (lat_cnt <= 0 && !hang) begin
               mul_res     = mul_model(lat_op1, lat_op2);
               mul_res_rdy = 1'b1;
               pending     = 1'b0;
               genuine     = 1'b1;
            end
         end else if (glitch && $urandom_range(0, 2) == 0) begin
            mul_res     = 32'hDEAD_BEEF;
            mul_res_rdy = 1'b1;
         end
         prev_in_rdy = mul_in_rdy;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one pair and hold it until accepted (bounded).
   task automatic push(input logic [31:0] a, input logic [31:0] b);
      bit ok = 1'b0;
      int k  = 0;
      a_in     = a;
      b_in     = b;
      in_valid = 1'b1;
      while (!ok && k < 200) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         k++;
      end
      in_valid = 1'b0;
      check("push_accepted", 32'(ok), 32'd1);
   endtask

   task automatic wait_drained(input string tag);
      int k = 0;
      while ((exp_q.size() != 0 || busy || out_valid) && k < 1000) begin
         cycles(1);
         k++;
      end
      check(tag, 32'(k < 1000), 32'd1);
   endtask

   task automatic wait_pending();
      int k = 0;
      while (!pending && k < 50) begin
         cycles(1);
         k++;
      end
      check("issue_seen", 32'(pending), 32'd1);
   endtask

   initial begin
      logic [31:0] ra, rb;

      // Reset state
      cycles(3);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_rdy", 32'(mul_in_rdy), 32'd0);
      check("rst_op1", mul_op1, 32'd0);
      check("rst_out_res", out_res, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      cycles(1);
      check("in_ready_after_rst", 32'(in_ready), 32'd1);

      // 1: single product and issue latency
      push(32'h4000_0000, 32'h4040_0000);
      check("lat_not_yet", 32'(mul_in_rdy), 32'd0);
      cycles(1);
      check("lat_issue", 32'(mul_in_rdy), 32'd1);
      check("issue_op1", mul_op1, 32'h4000_0000);
      check("issue_op2", mul_op2, 32'h4040_0000);
      wait_drained("t1_drain");

      // 2: back-to-back pairs, special values pass straight through
      push(32'h3FC0_0000, 32'h3FC0_0000);
      push(32'h7F80_0000, 32'h0000_0000);
      wait_drained("t2_drain");

      // 3: consumer stalled, FIFO fills, stray strobes must be ignored
      glitch    = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < int'(DEPTH) + 1; i++) push($urandom, $urandom);
      cycles(10);
      check("full_count", 32'(fifo_count), 32'(DEPTH));
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_busy", 32'(busy), 32'd1);
      ra       = $urandom;
      rb       = $urandom;
      a_in     = ra;
      b_in     = rb;
      in_valid = 1'b1;
      cycles(3);
      check("full_no_push", 32'(fifo_count), 32'(DEPTH));
      out_ready = 1'b1;
      push(ra, rb);
      wait_drained("t3_drain");
      glitch = 1'b0;

      // 4: push and pop on the same edge
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push($urandom, $urandom);
      cycles(10);
      check("pp_pre_count", 32'(fifo_count), 32'd2);
      a_in      = $urandom;
      b_in      = $urandom;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cycles(1);
      in_valid = 1'b0;
      check("pp_same_count", 32'(fifo_count), 32'd2);
      wait_drained("t4_drain");

      // 5: reset during WAIT discards the in-flight op and the FIFO
      hang = 1'b1;
      push(32'h1111_1111, 32'h2222_2222);
      push(32'h3333_3333, 32'h4444_4444);
      wait_pending();
      cycles(3);
      check("wait_no_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      cycles(1);
      rst = 1'b1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      hang = 1'b0;
      push(32'h4000_0000, 32'h4040_0000);
      wait_drained("t5_drain");

`ifdef FP_MUL_TIMEOUT_EN
      // 6: watchdog returns QNAN after TO_CYC WAIT cycles
      begin
         int k = 0;
         hang = 1'b1;
         push(32'h3F80_0000, 32'h3F80_0000);
         exp_q[exp_q.size() - 1] = 32'h7FC0_0000;
         while (!mul_in_rdy && k < 20) begin
            cycles(1);
            k++;
         end
         k = 0;
         while (!out_valid && k < 50) begin
            cycles(1);
            k++;
         end
         check("to_cycles", 32'(k), 32'(TO_CYC + 1));
         check("to_res", out_res, 32'h7FC0_0000);
         check("to_err", 32'(timeout_err), 32'd1);
         pending = 1'b0;
         hang    = 1'b0;
         push(32'h4000_0000, 32'h4040_0000);
         wait_drained("t6_drain");
         check("to_err_sticky", 32'(timeout_err), 32'd1);
         rst = 1'b0;
         cycles(1);
         rst = 1'b1;
         check("to_err_cleared", 32'(timeout_err), 32'd0);
      end
`endif

      check("sb_empty_end", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
